alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle controller that fronts the combinational ALU. It accepts one operation per start/done handshake and latches the operands. Single-cycle ops are issued to the ALU as a one-cycle one-hot strobe, and the ALU result is captured. MUL (radix-4 Booth) and DIV (non-restoring) run iteratively inside this block. Results land in HI/LO registers read by the datapath.

Parameters:
WIDTH, 32, operand/result width; MUL/DIV iteration counts derive from it (WIDTH/2 and WIDTH)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
opcode  in  5  operation code: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010
opA  in  WIDTH  operand A (multiplicand / dividend)
opB  in  WIDTH  operand B (multiplier / divisor / shift amount)
alu_strobe  out  13  one-hot ALU select, bit order as opcode list above
alu_clow  in  WIDTH  ALU low result
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
error  out  1  valid with done: illegal opcode or divide by zero
HI  out  WIDTH  high result / remainder
LO  out  WIDTH  low result / quotient

Behaviour:
- Reset (async, any state): state=IDLE; HI=LO=0; alu_strobe=0; busy=done=error=0; all internal counters and accumulators are cleared.
- States: IDLE, ISSUE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- IDLE, start=1 (opcode, opA, opB latched on the same edge):
  - simple op -> ISSUE
  - MUL -> MUL_RUN
  - DIV with opB!=0 -> DIV_RUN
  - DIV with opB=0 -> DONE, error=1, HI=opA, LO=all ones
  - illegal opcode -> DONE, error=1, HI/LO unchanged
- start while busy: ignored, with no effect on the running op.
- ISSUE: alu_strobe drives the single bit for the latched opcode, from the latched operands. LO<=alu_clow at the end of the cycle. HI is unchanged. Next state DONE.
- alu_strobe is zero in every state except ISSUE.
- MUL_RUN: signed radix-4 Booth.
  - Each cycle consumes 3 bits of opB (bit -1 = 0) and adds or subtracts 0, ±A or ±2A, shifted, into a 2*WIDTH accumulator.
  - Runs WIDTH/2 = 16 cycles, then DONE with {HI,LO}=full signed product.
- DIV_RUN: signed non-restoring division.
  - Operates on magnitudes with a WIDTH+1 partial remainder.
  - Per iteration: shift; subtract if the remainder is >=0, else add; quotient bit = ~sign.
  - 32 cycles, then DIV_FIX.
- DIV_FIX (1 cycle): add the divisor if the remainder is negative, then apply signs.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder. Next state DONE.
- DIV overflow: 0x80000000 / -1 -> LO=0x80000000, HI=0, error=0 (wraps).
- DONE: done=1 for exactly one cycle, error valid in the same cycle, then IDLE. A new start is accepted in the cycle after done.
- Latency (accepting edge to done cycle): simple 2, MUL 17, DIV 34, error 1.
- HI/LO change only on completion of an op (ISSUE/DIV_FIX/MUL final step or error write) or on reset. They hold between ops.

Decomposition:
- Shared package `alu_pkg`: opcode localparams, the strobe bit index per op, and the state encoding. The ALU and the control unit use the same package.
- One natural sub-module, `booth_div_core`: holds the accumulator, remainder and iteration counter. It takes a start/mode input and reports last_iter. The FSM and handshake stay in `alu_sequencer`.

Test Plan:
- ADD (00011), opA=5, opB=9, ALU model returns 14 -> alu_strobe=bit ADD for exactly one cycle; LO=0x0000000E; HI unchanged; done at cycle 2.
- MUL, opA=0xFFFFFFF9 (-7), opB=6 -> done at cycle 17, HI=0xFFFFFFFF, LO=0xFFFFFFD6, error=0.
- MUL, opA=opB=0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV, opA=-17, opB=5 -> done at cycle 34, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFE (-2).
- DIV by zero, opA=100, opB=0 -> done at cycle 1 with error=1, HI=0x64, LO=0xFFFFFFFF. Opcode 11111 -> error=1, HI/LO unchanged.
- Start MUL, pulse start with DIV at cycle 5 (ignored), assert clear at cycle 9 -> immediate IDLE, all outputs 0. A subsequent ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its control unit: opcodes, strobe bit
// positions, sequencer states and the iterative core's operating mode.
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   localparam int STROBE_W = 13;
   localparam int STB_ADD  = 0;
   localparam int STB_SUB  = 1;
   localparam int STB_SHR  = 2;
   localparam int STB_SHRA = 3;
   localparam int STB_SHL  = 4;
   localparam int STB_ROR  = 5;
   localparam int STB_ROL  = 6;
   localparam int STB_AND  = 7;
   localparam int STB_OR   = 8;
   localparam int STB_MUL  = 9;
   localparam int STB_DIV  = 10;
   localparam int STB_NEG  = 11;
   localparam int STB_NOT  = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_MUL_RUN,
      ST_DIV_RUN,
      ST_DIV_FIX,
      ST_DONE
   } state_t;

   typedef enum logic {
      CORE_MUL,
      CORE_DIV
   } coreMode_t;

   // Only ops handed to the combinational ALU get a strobe; MUL/DIV run in-house.
   function automatic logic [STROBE_W-1:0] strobeFor(input logic [4:0] op);
      logic [STROBE_W-1:0] s;
      s = '0;
      case (op)
         OP_ADD:  s[STB_ADD]  = 1'b1;
         OP_SUB:  s[STB_SUB]  = 1'b1;
         OP_SHR:  s[STB_SHR]  = 1'b1;
         OP_SHRA: s[STB_SHRA] = 1'b1;
         OP_SHL:  s[STB_SHL]  = 1'b1;
         OP_ROR:  s[STB_ROR]  = 1'b1;
         OP_ROL:  s[STB_ROL]  = 1'b1;
         OP_AND:  s[STB_AND]  = 1'b1;
         OP_OR:   s[STB_OR]   = 1'b1;
         OP_NEG:  s[STB_NEG]  = 1'b1;
         OP_NOT:  s[STB_NOT]  = 1'b1;
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic logic isSimple(input logic [4:0] op);
      return |strobeFor(op);
   endfunction

endpackage

// File: rtl/booth_div_core.sv
// Iterative datapath: radix-4 Booth multiply and signed non-restoring divide.
// Holds accumulator, partial remainder and iteration counter; no handshake.
module booth_div_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             i_start,
   input  coreMode_t        i_mode,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_opA,
   input  logic [WIDTH-1:0] i_opB,
   output logic             o_lastIter,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

   coreMode_t          r_mode;
   logic [CW-1:0]      r_count;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH:0]     r_mplier;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_divisor;
   logic               r_negQ;
   logic               r_negR;

   logic [WIDTH-1:0]   w_magA;
   logic [WIDTH-1:0]   w_magB;
   logic [2*WIDTH-1:0] w_partial;
   logic [2*WIDTH-1:0] w_accNext;
   logic [WIDTH:0]     w_remShift;
   logic [WIDTH:0]     w_remNext;
   logic [WIDTH-1:0]   w_quoNext;
   logic [WIDTH:0]     w_remFix;
   logic [WIDTH-1:0]   w_quoSigned;
   logic [WIDTH-1:0]   w_remSigned;

   assign w_magA = i_opA[WIDTH-1] ? -i_opA : i_opA;
   assign w_magB = i_opB[WIDTH-1] ? -i_opB : i_opB;

   // Booth digit from the low triplet; the multiplicand is pre-shifted each step.
   always_comb begin
      w_partial = '0;
      case (r_mplier[2:0])
         3'b001, 3'b010: w_partial = r_mcand;
         3'b011:         w_partial = r_mcand << 1;
         3'b100:         w_partial = -(r_mcand << 1);
         3'b101, 3'b110: w_partial = -r_mcand;
         default:        w_partial = '0;
      endcase
   end

   assign w_accNext = r_acc + w_partial;

   assign w_remShift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
   assign w_remNext  = r_rem[WIDTH] ? w_remShift + {1'b0, r_divisor}
                                    : w_remShift - {1'b0, r_divisor};
   assign w_quoNext  = {r_quo[WIDTH-2:0], ~w_remNext[WIDTH]};

   // Final correction and sign restoration: truncating quotient, dividend-signed remainder.
   assign w_remFix    = r_rem[WIDTH] ? r_rem + {1'b0, r_divisor} : r_rem;
   assign w_quoSigned = r_negQ ? -r_quo : r_quo;
   assign w_remSigned = r_negR ? -w_remFix[WIDTH-1:0] : w_remFix[WIDTH-1:0];

   assign o_lastIter = (r_count == ((r_mode == CORE_MUL) ? MUL_LAST : DIV_LAST));
   assign o_hi = (r_mode == CORE_MUL) ? w_accNext[2*WIDTH-1:WIDTH] : w_remSigned;
   assign o_lo = (r_mode == CORE_MUL) ? w_accNext[WIDTH-1:0]       : w_quoSigned;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_mode    <= CORE_MUL;
         r_count   <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
      end else if (i_start) begin
         r_mode    <= i_mode;
         r_count   <= '0;
         r_acc     <= '0;
         r_mcand   <= {{WIDTH{i_opA[WIDTH-1]}}, i_opA};
         r_mplier  <= {i_opB, 1'b0};
         r_rem     <= '0;
         r_quo     <= w_magA;
         r_divisor <= w_magB;
         r_negQ    <= i_opA[WIDTH-1] ^ i_opB[WIDTH-1];
         r_negR    <= i_opA[WIDTH-1];
      end else if (i_step) begin
         r_count <= r_count + CW'(1);
         if (r_mode == CORE_MUL) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 2;
            r_mplier <= {2'b00, r_mplier[WIDTH:2]};
         end else begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU front end: start/done handshake, one-hot ALU strobe for
// simple ops, iterative MUL/DIV via booth_div_core, results into HI/LO.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic [4:0]          opcode,
   input  logic [WIDTH-1:0]    opA,
   input  logic [WIDTH-1:0]    opB,
   output logic [STROBE_W-1:0] alu_strobe,
   input  logic [WIDTH-1:0]    alu_clow,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [WIDTH-1:0]    HI,
   output logic [WIDTH-1:0]    LO
);

   state_t           r_state;
   state_t           w_nextState;
   logic [4:0]       r_opcode;
   logic             r_error;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_isMul;
   logic             w_isDiv;
   logic             w_divZero;
   logic             w_simple;
   logic             w_illegal;
   logic             w_coreStart;
   logic             w_step;
   logic             w_lastIter;
   logic [WIDTH-1:0] w_coreHi;
   logic [WIDTH-1:0] w_coreLo;

   assign w_isMul     = (opcode == OP_MUL);
   assign w_isDiv     = (opcode == OP_DIV);
   assign w_divZero   = w_isDiv && (opB == '0);
   assign w_simple    = isSimple(opcode);
   assign w_illegal   = !(w_simple || w_isMul || w_isDiv);
   assign w_coreStart = (r_state == ST_IDLE) && start && (w_isMul || (w_isDiv && !w_divZero));
   assign w_step      = (r_state == ST_MUL_RUN) || (r_state == ST_DIV_RUN);

   booth_div_core #(.WIDTH(WIDTH)) u_core (
      .clock      (clock),
      .clear      (clear),
      .i_start    (w_coreStart),
      .i_mode     (w_isDiv ? CORE_DIV : CORE_MUL),
      .i_step     (w_step),
      .i_opA      (opA),
      .i_opB      (opB),
      .o_lastIter (w_lastIter),
      .o_hi       (w_coreHi),
      .o_lo       (w_coreLo)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      alu_strobe  = '0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_simple)                 w_nextState = ST_ISSUE;
               else if (w_isMul)             w_nextState = ST_MUL_RUN;
               else if (w_isDiv && !w_divZero) w_nextState = ST_DIV_RUN;
               else                          w_nextState = ST_DONE;
            end
         end
         ST_ISSUE: begin
            alu_strobe  = strobeFor(r_opcode);
            w_nextState = ST_DONE;
         end
         ST_MUL_RUN: if (w_lastIter) w_nextState = ST_DONE;
         ST_DIV_RUN: if (w_lastIter) w_nextState = ST_DIV_FIX;
         ST_DIV_FIX: w_nextState = ST_DONE;
         ST_DONE:    w_nextState = ST_IDLE;
         default:    w_nextState = ST_IDLE;
      endcase
   end

   // HI/LO are written only when an operation completes, so they hold between ops.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_opcode <= '0;
         r_error  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_opcode <= opcode;
                  r_error  <= w_illegal || w_divZero;
                  if (w_divZero) begin
                     r_hi <= opA;
                     r_lo <= '1;
                  end
               end
            end
            ST_ISSUE: r_lo <= alu_clow;
            ST_MUL_RUN: begin
               if (w_lastIter) begin
                  r_hi <= w_coreHi;
                  r_lo <= w_coreLo;
               end
            end
            ST_DIV_FIX: begin
               r_hi <= w_coreHi;
               r_lo <= w_coreLo;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (r_state != ST_IDLE);
   assign done  = (r_state == ST_DONE);
   assign error = done && r_error;
   assign HI    = r_hi;
   assign LO    = r_lo;

endmodule
